// File: rtl/seg7_scan_pkg.sv
// Shared definitions for the seg7_scan display back-end: widths, digit index type,
// blank patterns and the active-low hex7 segment codes ({g,f,e,d,c,b,a}).
package seg7_scan_pkg;

  localparam int unsigned DISP_W = 16;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIG_N  = 4;

  typedef logic [1:0] digit_t;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam logic [DIG_N-1:0] AN_OFF  = 4'hF;

  localparam logic [SEG_W-1:0] HEX7_0 = 7'h40;
  localparam logic [SEG_W-1:0] HEX7_1 = 7'h79;
  localparam logic [SEG_W-1:0] HEX7_2 = 7'h24;
  localparam logic [SEG_W-1:0] HEX7_3 = 7'h30;
  localparam logic [SEG_W-1:0] HEX7_4 = 7'h19;
  localparam logic [SEG_W-1:0] HEX7_5 = 7'h12;
  localparam logic [SEG_W-1:0] HEX7_6 = 7'h02;
  localparam logic [SEG_W-1:0] HEX7_7 = 7'h78;
  localparam logic [SEG_W-1:0] HEX7_8 = 7'h00;
  localparam logic [SEG_W-1:0] HEX7_9 = 7'h10;
  localparam logic [SEG_W-1:0] HEX7_A = 7'h08;
  localparam logic [SEG_W-1:0] HEX7_B = 7'h03;
  localparam logic [SEG_W-1:0] HEX7_C = 7'h46;
  localparam logic [SEG_W-1:0] HEX7_D = 7'h21;
  localparam logic [SEG_W-1:0] HEX7_E = 7'h06;
  localparam logic [SEG_W-1:0] HEX7_F = 7'h0E;

endpackage

// File: rtl/seg7_scan_hex7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex7seg
  import seg7_scan_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    case (nibble)
      4'h0: seg_c = HEX7_0;
      4'h1: seg_c = HEX7_1;
      4'h2: seg_c = HEX7_2;
      4'h3: seg_c = HEX7_3;
      4'h4: seg_c = HEX7_4;
      4'h5: seg_c = HEX7_5;
      4'h6: seg_c = HEX7_6;
      4'h7: seg_c = HEX7_7;
      4'h8: seg_c = HEX7_8;
      4'h9: seg_c = HEX7_9;
      4'hA: seg_c = HEX7_A;
      4'hB: seg_c = HEX7_B;
      4'hC: seg_c = HEX7_C;
      4'hD: seg_c = HEX7_D;
      4'hE: seg_c = HEX7_E;
      default: seg_c = HEX7_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// 4-digit multiplexed common-anode hex display scanner with per-frame snapshot.
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DISP_W-1:0] value,
  input  logic              en,
  output logic [DIG_N-1:0]  an,
  output logic [SEG_W-1:0]  seg,
  output logic              dp,
  output logic              frame
);

  localparam logic [DIV_W-1:0] BLANK_V = DIV_W'(BLANK_CYC);

  logic [DIV_W-1:0]  cnt;
  digit_t            d;
  logic [DISP_W-1:0] snap;
  logic              tick_c;
  logic              frame_end_c;
  logic [NIB_W-1:0]  nib_c;
  logic [SEG_W-1:0]  seg_nxt_c;
  logic              lzb_c;
  logic [DIG_N-1:0]  an_nxt_c;

  assign tick_c      = (cnt == '1);
  assign frame_end_c = tick_c && (d == 2'd3);
  assign nib_c       = NIB_W'(snap >> {d, 2'b00});

  hex7seg u_hex7seg (
    .nibble (nib_c),
    .seg_c  (seg_nxt_c)
  );

`ifdef SEG7_LZB_EN
  // A digit is suppressed when it and every digit to its left are zero.
  always_comb begin
    lzb_c = 1'b0;
    case (d)
      2'd1:    lzb_c = (snap[15:4]  == '0);
      2'd2:    lzb_c = (snap[15:8]  == '0);
      2'd3:    lzb_c = (snap[15:12] == '0);
      default: lzb_c = 1'b0;
    endcase
  end
`else
  assign lzb_c = 1'b0;
`endif

  always_comb begin
    an_nxt_c = AN_OFF;
    if (!((cnt < BLANK_V) || lzb_c)) begin
      an_nxt_c = ~(4'b0001 << d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      d     <= '0;
      snap  <= '0;
      an    <= AN_OFF;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else if (!en) begin
      // Idle: keep tracking value so scanning starts on fresh data.
      cnt   <= '0;
      d     <= '0;
      snap  <= value;
      an    <= AN_OFF;
      seg   <= SEG_OFF;
      dp    <= 1'b1;
      frame <= 1'b0;
    end else begin
      cnt   <= cnt + DIV_W'(1);
      if (tick_c) begin
        d <= d + 2'd1;
      end
      if (frame_end_c) begin
        snap <= value;
      end
      an    <= an_nxt_c;
      seg   <= seg_nxt_c;
      dp    <= 1'b1;
      frame <= frame_end_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan (DIV_W=3, BLANK_CYC=1) with a cycle scoreboard.
module tb_seg7_scan;

  localparam int DIV_W     = 3;
  localparam int BLANK_CYC = 1;
  localparam int SLOT      = 1 << DIV_W;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  exp_t q[$];

  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          m_cnt;
  int          m_dig;
  logic [15:0] m_snap;
  exp_t        m_out;

  seg7_scan #(.DIV_W(DIV_W), .BLANK_CYC(BLANK_CYC)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .en    (en),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .frame (frame)
  );

  always #5 clk = ~clk;

  function automatic logic model_lzb(input logic [15:0] s, input int dig);
`ifdef SEG7_LZB_EN
    logic [15:0] upper;
    upper = s >> (4 * dig);
    return (dig != 0) && (upper == 16'h0000);
`else
    return 1'b0;
`endif
  endfunction

  // Reference behaviour for one rising edge, using inputs held stable before it.
  task automatic model_edge();
    int nib;
    if (rst || !en) begin
      m_out.an    = 4'hF;
      m_out.seg   = 7'h7F;
      m_out.frame = 1'b0;
      m_cnt       = 0;
      m_dig       = 0;
      m_snap      = rst ? 16'h0000 : value;
    end else begin
      nib         = (m_snap >> (4 * m_dig)) & 15;
      m_out.seg   = lut[nib];
      if (m_cnt < BLANK_CYC || model_lzb(m_snap, m_dig)) m_out.an = 4'hF;
      else begin
        case (m_dig)
          0: m_out.an = 4'b1110;
          1: m_out.an = 4'b1101;
          2: m_out.an = 4'b1011;
          default: m_out.an = 4'b0111;
        endcase
      end
      m_out.frame = (m_cnt == SLOT - 1) && (m_dig == 3);
      if (m_out.frame) m_snap = value;
      if (m_cnt == SLOT - 1) m_dig = (m_dig + 1) % 4;
      m_cnt = (m_cnt + 1) % SLOT;
    end
    m_out.dp = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock: model predicts, scoreboard compares the DUT one step after the edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    model_edge();
    q.push_back(m_out);
    #1;
    e = q.pop_front();
    chk("sb_an", 32'(an), 32'(e.an));
    chk("sb_seg", 32'(seg), 32'(e.seg));
    chk("sb_dp", 32'(dp), 32'(e.dp));
    chk("sb_frame", 32'(frame), 32'(e.frame));
  endtask

  initial begin
    int last_f;
    int nframes;
    logic seen3;
    logic bad_digit;

    rst = 1'b1; en = 1'b0; value = 16'h0000;
    m_cnt = 0; m_dig = 0; m_snap = '0; m_out = '0;

    // Reset
    step(); step();
    chk("rst_an", 32'(an), 32'h0F);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'h1);
    chk("rst_frame", 32'(frame), 32'h0);

    // Scan order and frame snapshot, en raised at E1
    rst = 1'b0; value = 16'h12AF;
    step(); step();
    en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1 || k == 9 || k == 17 || k == 25) chk("blank_an", 32'(an), 32'h0F);
      if (k >= 2 && k <= 8) begin
        chk("d0_an", 32'(an), 32'hE);
        chk("d0_seg", 32'(seg), 32'h0E);
      end
      if (k >= 10 && k <= 16) begin
        chk("d1_an", 32'(an), 32'hD);
        chk("d1_seg", 32'(seg), 32'h08);
      end
      if (k == 12) value = 16'h0000;
      if (k >= 18 && k <= 24) begin
        chk("d2_an", 32'(an), 32'hB);
        chk("d2_seg", 32'(seg), 32'h24);
      end
      if (k >= 26 && k <= 32) begin
        chk("d3_an", 32'(an), 32'h7);
        chk("d3_seg", 32'(seg), 32'h79);
      end
      chk("frame_pos", 32'(frame), 32'(k == 32));
      if (k >= 34 && k <= 40) chk("new_seg", 32'(seg), 32'h40);
    end

    // Enable gating mid-slot, then restart at digit 0 with current value
    step(); step();
    en = 1'b0; value = 16'h5A3C;
    step();
    chk("gate_an", 32'(an), 32'h0F);
    chk("gate_seg", 32'(seg), 32'h7F);
    step();
    en = 1'b1;
    step();
    chk("restart_blank", 32'(an), 32'h0F);
    step();
    chk("restart_an", 32'(an), 32'hE);
    chk("restart_seg", 32'(seg), 32'h46);

    // Reset asserted mid-scan
    for (int k = 0; k < 11; k++) step();
    rst = 1'b1;
    step();
    chk("mrst_an", 32'(an), 32'h0F);
    chk("mrst_seg", 32'(seg), 32'h7F);
    chk("mrst_dp", 32'(dp), 32'h1);
    chk("mrst_frame", 32'(frame), 32'h0);
    rst = 1'b0; en = 1'b0; value = 16'hBEEF;
    step();

    // Frame rate: pulses exactly 4*2^DIV_W apart, one cycle wide
    en = 1'b1;
    last_f = -1; nframes = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (frame) begin
        if (last_f >= 0) chk("frame_period", 32'(k - last_f), 32'(4 * SLOT));
        else chk("frame_first", 32'(k), 32'(4 * SLOT));
        last_f = k;
        nframes++;
      end
    end
    chk("frame_count", 32'(nframes), 32'(200 / (4 * SLOT)));

    // Leading zeros
    en = 1'b0; value = 16'h0030;
    step();
    en = 1'b1;
    seen3 = 1'b0; bad_digit = 1'b0;
    for (int k = 1; k <= 4 * SLOT; k++) begin
      step();
      if (an[3] == 1'b0) seen3 = 1'b1;
      if (an == 4'b1101 && seg != 7'h30) bad_digit = 1'b1;
      if (an == 4'b1110 && seg != 7'h40) bad_digit = 1'b1;
      if (an == 4'b0111 && seg != 7'h40) bad_digit = 1'b1;
    end
    chk("lz_digits", 32'(bad_digit), 32'h0);
`ifdef SEG7_LZB_EN
    chk("lzb_d3_off", 32'(seen3), 32'h0);
`else
    chk("nolzb_d3_on", 32'(seen3), 32'h1);
`endif
    en = 1'b0; value = 16'h0000;
    step();
    en = 1'b1;
    bad_digit = 1'b0;
    for (int k = 1; k <= 4 * SLOT; k++) begin
      step();
`ifdef SEG7_LZB_EN
      if (an != 4'hF && an != 4'b1110) bad_digit = 1'b1;
`else
      if (an == 4'b0111) bad_digit = 1'b1;
`endif
    end
`ifdef SEG7_LZB_EN
    chk("lzb_zero_only_d0", 32'(bad_digit), 32'h0);
`else
    chk("nolzb_zero_d3", 32'(bad_digit), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Display back-end for the educational CPU.
- Consumes the 16-bit `result` word that the register file exposes from r2 and drives a 4-digit, common-anode, multiplexed 7-segment display in hex.
- Scans one digit at a time from a prescaled clock.
- Snapshots the input once per frame so the display never tears mid-scan.

Parameters:
- DIV_W, 16: prescaler width. One digit slot lasts 2^DIV_W clk cycles.
- BLANK_CYC, 2: anti-ghost blanking cycles at the start of each digit slot. Constraint: 0 <= BLANK_CYC < 2^DIV_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- value  in  16  word to display, normally the register-file `result`.
- en  in  1  display enable.
- an  out  4  digit anodes, active low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low; constant 1.
- frame  out  1  one-cycle pulse, registered, high the cycle after a snapshot capture.

Behaviour:
- Reset (synchronous, rst=1 at posedge): cnt=0, d=0, snap=0, an=4'hF, seg=7'h7F, dp=1, frame=0. Reset applied mid-scan forces these values at the next edge.
- en=0:
  - cnt<=0, d<=0, snap<=value every cycle.
  - an<=4'hF, seg<=7'h7F, frame<=0.
- en=1:
  - cnt<=cnt+1 with DIV_W-bit wrap; tick = (cnt == all-ones).
  - On tick: d<=d+1 (2-bit, wraps 3->0).
  - If d==3 on tick: snap<=value, and frame<=1 for the following cycle only.
- Output registers, 1-cycle latency from the current cnt/d/snap:
  - an <= (cnt < BLANK_CYC) ? 4'hF : ~(4'b0001 << d).
  - seg <= hex7(snap[4d+3:4d]).
- hex7 encoding, 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, 7-bit).
- A change on value mid-frame is invisible until the next frame boundary.
- frame rises exactly once per 4*2^DIV_W cycles while en=1.
- When en rises, scanning starts at digit 0 using the snapshot taken in the last en=0 cycle.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined: digit k (k=3..1) is blanked (its anode stays high during its slot) when snap nibbles k..3 are all zero. Digit 0 is always shown. Blanking is evaluated on snap, so it is stable per frame.
- Undefined: all four digits are always shown.

Decomposition:
- Shared header pu.vh holds the 16-bit display width macro and the hex7 segment constants.
- Typedef for digit index (2-bit) goes in the same shared definitions.
- One natural combinational sub-module: hex7seg (4-bit nibble in, 7-bit active-low segments out), instanced once.
- Counters, snapshot register and output registers stay in seg7_scan.

Test Plan (DIV_W=3, BLANK_CYC=1 unless noted):
- Reset: rst=1 for 2 cycles -> an=4'hF, seg=7'h7F, dp=1, frame=0; same result when rst is asserted mid-scan.
- Scan order, value=16'h12AF with en low then raised at edge E1:
  - E2..E8: an=4'b1110, seg=7'h0E.
  - E9: an=4'hF.
  - E10..E16: an=4'b1101, seg=7'h08.
  - Then digit 2 shows '2' (7'h24) and digit 3 shows '1' (7'h79).
- Frame snapshot: change value to 16'h0000 during digit 1 -> digits 2 and 3 still show 2 and 1. One frame pulse follows the digit-3 slot, and the next frame shows 7'h40 on all digits.
- Enable gating: drop en mid-slot -> next edge an=4'hF, seg=7'h7F. Re-raise en -> scan restarts at digit 0 with the current value.
- Frame rate: en=1 for 200 cycles -> exactly one frame pulse every 32 cycles, each 1 cycle wide.
- SEG7_LZB_EN defined:
  - value=16'h0030: digits 3 and 2 are never active; digit 1 shows 7'h30, digit 0 shows 7'h40.
  - value=0: only an[0] is ever driven low.
